// File: rtl/branch_resolver.sv
// Branch resolver: turns comparator flags plus funct3 into a registered
// taken/not-taken decision for RV32I branches and JAL/JALR, and issues a
// redirect PC with a bounded front-end flush under static predict-not-taken.
module branch_resolver #(
   parameter int nb_bits      = 32,
   parameter int flush_cycles = 2    // legal range 1..15
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               kill_i,
   input  logic               is_branch_i,
   input  logic               is_jump_i,
   input  logic [2:0]         funct3_i,
   input  logic               s_greater_i,
   input  logic               s_equal_i,
   input  logic               s_lesser_i,
   input  logic               u_greater_i,
   input  logic               u_equal_i,
   input  logic               u_lesser_i,
   input  logic [nb_bits-1:0] target_i,
   output logic               valid_o,
   output logic               taken_o,
   output logic               redirect_o,
   output logic [nb_bits-1:0] redirect_pc_o,
   output logic               flush_o,
   output logic               misalign_o
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   // The counter loads flush_cycles-1 so that leaving FLUSH on count==0
   // gives exactly flush_cycles flush cycles.
   localparam logic [3:0] c_cnt_load = 4'(flush_cycles - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic               r_valid;
   logic               r_taken;
   logic               r_redirect;
   logic               r_misalign;
   logic [nb_bits-1:0] r_pc;

   logic               w_accept;
   logic               w_cond;
   logic               w_taken;
   logic               w_aligned;
   logic               w_redirect;

   assign ready_o    = (r_state == S_IDLE);
   assign w_accept   = valid_i & ready_o & ~kill_i;
   assign w_taken    = is_jump_i | (is_branch_i & w_cond);
   assign w_aligned  = ~target_i[1];
   assign w_redirect = w_accept & w_taken & w_aligned;

   // Branch condition decode from funct3; reserved codes 010/011 never take.
   always_comb begin
      // NOTE: default first so every path assigns w_cond and no latch is inferred.
      w_cond = 1'b0;
      case (funct3_i)
         3'b000:  w_cond = s_equal_i;
         3'b001:  w_cond = ~s_equal_i;
         3'b100:  w_cond = s_lesser_i;
         3'b101:  w_cond = s_greater_i | s_equal_i;
         3'b110:  w_cond = u_lesser_i;
         3'b111:  w_cond = u_greater_i | u_equal_i;
         default: w_cond = 1'b0;
      endcase
   end

   // FSM next-state and flush counter; kill aborts any flush in progress.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (kill_i) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_redirect) begin
                  w_state_nxt = S_FLUSH;
                  w_cnt_nxt   = c_cnt_load;
               end
            end
            S_FLUSH: begin
               if (r_cnt == 4'd0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // FSM state register and flush counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Registered result: one-cycle pulses plus held direction and redirect PC.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_valid    <= 1'b0;
         r_taken    <= 1'b0;
         r_redirect <= 1'b0;
         r_misalign <= 1'b0;
         r_pc       <= '0;
      end else begin
         r_valid    <= w_accept;
         r_redirect <= w_redirect;
         r_misalign <= w_accept & w_taken & ~w_aligned;
         if (w_accept) begin
            r_taken <= w_taken;
         end
         if (w_redirect) begin
            r_pc <= {target_i[nb_bits-1:1], 1'b0};
         end
      end
   end

   assign valid_o       = r_valid;
   assign taken_o       = r_taken;
   assign redirect_o    = r_redirect;
   assign misalign_o    = r_misalign;
   assign redirect_pc_o = r_pc;
   assign flush_o       = (r_state == S_FLUSH);

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
module tb_branch_resolver;

   localparam int nb_bits = 32;

   logic               clk_i = 1'b0;
   logic               rst_n_i;
   logic               valid_i;
   logic               ready_o;
   logic               kill_i;
   logic               is_branch_i;
   logic               is_jump_i;
   logic [2:0]         funct3_i;
   logic               s_greater_i, s_equal_i, s_lesser_i;
   logic               u_greater_i, u_equal_i, u_lesser_i;
   logic [nb_bits-1:0] target_i;
   logic               valid_o;
   logic               taken_o;
   logic               redirect_o;
   logic [nb_bits-1:0] redirect_pc_o;
   logic               flush_o;
   logic               misalign_o;

   int checks = 0;
   int errors = 0;

   branch_resolver #(.nb_bits(nb_bits), .flush_cycles(2)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .kill_i        (kill_i),
      .is_branch_i   (is_branch_i),
      .is_jump_i     (is_jump_i),
      .funct3_i      (funct3_i),
      .s_greater_i   (s_greater_i),
      .s_equal_i     (s_equal_i),
      .s_lesser_i    (s_lesser_i),
      .u_greater_i   (u_greater_i),
      .u_equal_i     (u_equal_i),
      .u_lesser_i    (u_lesser_i),
      .target_i      (target_i),
      .valid_o       (valid_o),
      .taken_o       (taken_o),
      .redirect_o    (redirect_o),
      .redirect_pc_o (redirect_pc_o),
      .flush_o       (flush_o),
      .misalign_o    (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one op; flags given as {greater,equal,lesser}.
   task automatic drive(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                        input logic [2:0] sf, input logic [2:0] uf, input logic [31:0] tgt);
      valid_i     = v;
      is_branch_i = br;
      is_jump_i   = jp;
      funct3_i    = f3;
      {s_greater_i, s_equal_i, s_lesser_i} = sf;
      {u_greater_i, u_equal_i, u_lesser_i} = uf;
      target_i    = tgt;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0);
   endtask

   // Advance one edge and sample 1 ns later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic tk, input logic rd,
                            input logic fl, input logic ma, input logic rdy);
      check({tag, ".valid"},    32'(valid_o),    32'(v));
      check({tag, ".taken"},    32'(taken_o),    32'(tk));
      check({tag, ".redirect"}, 32'(redirect_o), 32'(rd));
      check({tag, ".flush"},    32'(flush_o),    32'(fl));
      check({tag, ".misalign"}, 32'(misalign_o), 32'(ma));
      check({tag, ".ready"},    32'(ready_o),    32'(rdy));
   endtask

   initial begin
      rst_n_i = 1'b0;
      kill_i  = 1'b0;
      idle();
      #12;
      check_out("reset", 0, 0, 0, 0, 0, 1);
      check("reset.pc", redirect_pc_o, 32'h0);
      rst_n_i = 1'b1;
      step();

      // BEQ taken to 0x40: redirect + 2-cycle flush, ready low 2 cycles.
      drive(1, 1, 0, 3'b000, 3'b010, 3'b010, 32'h0000_0040);
      step();
      check_out("beq.c1", 1, 1, 1, 1, 0, 0);
      check("beq.pc", redirect_pc_o, 32'h0000_0040);
      idle();
      step();
      check_out("beq.c2", 0, 1, 0, 1, 0, 0);
      step();
      check_out("beq.c3", 0, 1, 0, 0, 0, 1);

      // A=0xFFFFFFFF, B=1: signed lesser, unsigned greater. Back-to-back accepts.
      drive(1, 1, 0, 3'b110, 3'b001, 3'b100, 32'h0000_0080);   // BLTU: not taken
      step();
      check_out("bltu", 1, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 3'b101, 3'b001, 3'b100, 32'h0000_0080);   // BGE: not taken
      step();
      check_out("bge", 1, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 3'b100, 3'b001, 3'b100, 32'h0000_0080);   // BLT: taken
      step();
      check_out("blt", 1, 1, 1, 1, 0, 0);
      check("blt.pc", redirect_pc_o, 32'h0000_0080);
      idle();
      step();
      step();
      check("blt.ready_back", 32'(ready_o), 32'd1);

      // JALR to 0x1003: target[1]=1 -> misalign, no redirect, pc held.
      drive(1, 0, 1, 3'b000, 3'b000, 3'b000, 32'h0000_1003);
      step();
      check_out("jalr_mis", 1, 1, 0, 0, 1, 1);
      check("jalr_mis.pc", redirect_pc_o, 32'h0000_0080);
      // JALR to 0x1001 (with is_branch also set, jump wins): pc 0x1000.
      drive(1, 1, 1, 3'b010, 3'b000, 3'b000, 32'h0000_1001);
      step();
      check_out("jalr_ok", 1, 1, 1, 1, 0, 0);
      check("jalr_ok.pc", redirect_pc_o, 32'h0000_1000);
      idle();
      step();
      step();

      // Reserved funct3=010 with all flags set: not taken.
      drive(1, 1, 0, 3'b010, 3'b111, 3'b111, 32'h0000_0300);
      step();
      check_out("f3_010", 1, 0, 0, 0, 0, 1);
      check("f3_010.pc", redirect_pc_o, 32'h0000_1000);
      // Non-branch op: valid, not taken.
      drive(1, 0, 0, 3'b000, 3'b010, 3'b010, 32'h0000_0400);
      step();
      check_out("nonbr", 1, 0, 0, 0, 0, 1);

      // Kill in IDLE blocks a taken accept.
      drive(1, 1, 0, 3'b000, 3'b010, 3'b010, 32'h0000_0440);
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      check_out("kill_idle", 0, 0, 0, 0, 0, 1);
      check("kill_idle.pc", redirect_pc_o, 32'h0000_1000);

      // Taken BNE, then kill during first FLUSH cycle with a new valid op.
      drive(1, 1, 0, 3'b001, 3'b100, 3'b100, 32'h0000_0500);
      step();
      check_out("bne", 1, 1, 1, 1, 0, 0);
      check("bne.pc", redirect_pc_o, 32'h0000_0500);
      drive(1, 1, 0, 3'b000, 3'b010, 3'b010, 32'h0000_0600);
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      idle();
      check_out("bne_kill", 0, 1, 0, 0, 0, 1);
      step();
      check_out("bne_kill2", 0, 1, 0, 0, 0, 1);
      check("bne_kill2.pc", redirect_pc_o, 32'h0000_0500);

      // Asynchronous reset between edges in the middle of a flush.
      drive(1, 1, 0, 3'b000, 3'b010, 3'b010, 32'h0000_0700);
      step();
      check_out("pre_rst", 1, 1, 1, 1, 0, 0);
      idle();
      #2;
      rst_n_i = 1'b0;
      #1;
      check_out("async_rst", 0, 0, 0, 0, 0, 1);
      check("async_rst.pc", redirect_pc_o, 32'h0);
      #1;
      rst_n_i = 1'b1;
      step();
      check_out("post_rst", 0, 0, 0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the greater/equal/lesser flag triples from the signed and unsigned comparators in the execute stage.
- Combines them with the branch funct3 to resolve RV32I conditional branches and JAL/JALR jumps.
- Registers the decision and issues a redirect PC plus a bounded front-end flush pulse train.
- Static predict-not-taken: every taken branch or jump redirects.

Parameters:
nb_bits, 32, width of PC and target buses
flush_cycles, 2, number of cycles flush_o stays high per redirect (legal range 1..15)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
valid_i  input  1  execute-stage op valid
ready_o  output  1  resolver can accept an op
kill_i  input  1  synchronous cancel from a later stage (exception/trap)
is_branch_i  input  1  op is a conditional branch
is_jump_i  input  1  op is JAL/JALR (unconditionally taken)
funct3_i  input  3  branch condition code
s_greater_i, s_equal_i, s_lesser_i  input  1 each  signed comparator flags (A vs B)
u_greater_i, u_equal_i, u_lesser_i  input  1 each  unsigned comparator flags
target_i  input  nb_bits  precomputed branch/jump target
valid_o  output  1  one-cycle pulse: a resolution result is presented
taken_o  output  1  resolved direction, qualified by valid_o
redirect_o  output  1  one-cycle pulse: fetch must load redirect_pc_o
redirect_pc_o  output  nb_bits  new fetch PC (target_i with bit 0 cleared)
flush_o  output  1  kill younger front-end ops
misalign_o  output  1  one-cycle pulse: taken target not 4-byte aligned

Behaviour:
- Reset (async, rst_n_i low): state IDLE; valid_o, taken_o, redirect_o, flush_o and misalign_o are 0; redirect_pc_o is 0; counter is 0; ready_o is 1 (decoded from IDLE).
- Accept: an op is accepted on a rising edge with valid_i & ready_o & ~kill_i.
- Ops with neither is_branch_i nor is_jump_i are accepted, produce valid_o=1 and taken_o=0, and nothing else.
- Condition when is_branch_i:
  - 000 BEQ: s_equal
  - 001 BNE: ~s_equal
  - 100 BLT: s_lesser
  - 101 BGE: s_greater | s_equal
  - 110 BLTU: u_lesser
  - 111 BGEU: u_greater | u_equal
  - 010 and 011: not taken, no other action
- is_jump_i forces taken=1 and overrides is_branch_i.
- Latency: 1 cycle. Outputs appear the cycle after acceptance and all pulses last exactly 1 cycle.
- Taken with target_i[1]==0: valid_o=1, taken_o=1, redirect_o=1, redirect_pc_o={target_i[nb_bits-1:1],1'b0}, flush_o=1; state goes to FLUSH.
- Taken with target_i[1]==1: valid_o=1, taken_o=1, misalign_o=1, no redirect, no flush; state stays IDLE.
- FSM:
  - IDLE → FLUSH on an aligned taken accept; counter loads flush_cycles-1.
  - In FLUSH: ready_o=0, flush_o=1, counter decrements every cycle.
  - FLUSH → IDLE on the edge where counter==0, so flush_o is high for exactly flush_cycles cycles, the first coinciding with redirect_o.
  - ready_o returns to 1 in the first IDLE cycle.
  - With flush_cycles=1: one FLUSH cycle, then IDLE.
- Outside a pulse, taken_o and redirect_pc_o hold their last values; valid_o=0 marks them stale.
- kill_i has highest priority and is synchronous:
  - No accept occurs that cycle.
  - Next cycle: all pulses and flush_o are 0 and state is IDLE.
  - This includes aborting an in-progress FLUSH and cancelling a result being registered that edge.
- valid_i while ready_o=0 is ignored; upstream must hold the op.
- Flags are used exactly as given; no cross-checking of mutually exclusive flags.
- Reset asserted mid-FLUSH: immediate return to reset values.

Test Plan:
- Reset release, then BEQ with funct3=000, s_equal=1, target=0x0000_0040, flush_cycles=2 → next cycle valid_o=1, taken_o=1, redirect_o=1, redirect_pc_o=0x40; flush_o high 2 cycles; ready_o low 2 cycles, then 1.
- BLT vs BLTU with A=0xFFFF_FFFF, B=1 (s_lesser=1, u_greater=1): BLT → taken_o=1; BLTU → taken_o=0, no redirect, ready_o stays 1, back-to-back accepts on consecutive cycles.
- JALR with target_i=0x0000_1003 → redirect_pc_o=0x0000_1002? Not used: target[1]=1, so misalign_o=1 and redirect_o=0. target_i=0x0000_1001 → redirect_pc_o=0x0000_1000, redirect_o=1.
- funct3=010 with is_branch_i=1 and all flags 1 → valid_o=1, taken_o=0, no redirect or flush.
- Taken BNE, then kill_i=1 in the first FLUSH cycle → flush_o=0 and ready_o=1 on the next cycle; a new valid_i in the kill cycle is not accepted.
- rst_n_i pulsed low asynchronously mid-FLUSH (between edges) → outputs go to reset values immediately, ready_o=1, no further flush_o.
